// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display controller:
// register map, CTRL field layout and the hex glyph table.
package seg7_pkg;

  localparam logic [1:0] REG_DIGITS = 2'd0;
  localparam logic [1:0] REG_DP     = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLANK_BIT = 1;
  localparam int CTRL_BRT_LSB   = 4;
  localparam int CTRL_BRT_W     = 4;
  localparam int STAT_PEND_BIT  = 16;

  typedef struct packed {
    logic [3:0] bright;
    logic       blank;
    logic       en;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{bright: 4'hF, blank: 1'b0, en: 1'b1};

  // Entry n occupies bits [7n+6:7n], segment order gfedcba, active-high.
  localparam logic [111:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    return GLYPH_TABLE[int'(nib) * 7 +: 7];
  endfunction

  function automatic ctrl_t ctrl_unpack(input logic [31:0] w);
    ctrl_t c;
    c.en     = w[CTRL_EN_BIT];
    c.blank  = w[CTRL_BLANK_BIT];
    c.bright = w[CTRL_BRT_LSB +: CTRL_BRT_W];
    return c;
  endfunction

  function automatic logic [31:0] ctrl_pack(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]                  = c.en;
    w[CTRL_BLANK_BIT]               = c.blank;
    w[CTRL_BRT_LSB +: CTRL_BRT_W]   = c.bright;
    return w;
  endfunction

endpackage

// File: rtl/seg7_hexdec.sv
// Combinational nibble-to-glyph decoder (active-high segments, gfedcba).
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_glyph(nib_i);

endmodule

// File: rtl/seg7_dispn.sv
// Register-programmed N-digit multiplexed 7-segment driver with PWM
// brightness, leading-zero blanking and frame-synchronised digit updates.
module seg7_dispn
  import seg7_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int SUB_DIV     = 3125,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit COM_ACT_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sel,
  input  logic            rw,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [6:0]      oSEG,
  output logic            oSEGDP,
  output logic [NDIG-1:0] oCOM
);

  localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int NIB_W = 4 * NDIG;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NDIG - 1);

  ctrl_t            ctrl_q, ctrl_d;
  logic [NIB_W-1:0] dig_stage_q, dig_stage_d, dig_act_q, dig_act_d;
  logic [NDIG-1:0]  dp_stage_q, dp_stage_d, dp_act_q, dp_act_d;
  logic             pend_q, pend_d;
  logic [15:0]      frame_q, frame_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [3:0]       sub_idx_q, sub_idx_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [NDIG-1:0]  com_q, com_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             wr, rd, wr_dig, wr_dp, wr_ctrl;
  logic             run, frame_end, boundary;
  logic [3:0]       nib_cur;
  logic             dp_cur, blank_cur;
  logic [NDIG-1:0]  lz_blank;
  logic [6:0]       glyph_cur;
  logic             unused_wdata;

  assign wr      = sel & rw;
  assign rd      = sel & ~rw;
  assign wr_dig  = wr && (addr == REG_DIGITS);
  assign wr_dp   = wr && (addr == REG_DP);
  assign wr_ctrl = wr && (addr == REG_CTRL);
  assign unused_wdata = ^wdata;

  // CTRL takes effect in the write cycle itself so the outputs registered
  // on that edge already reflect it.
  assign ctrl_d = wr_ctrl ? ctrl_unpack(wdata) : ctrl_q;
  assign run    = ctrl_d.en;

  assign frame_end = (sub_cnt_q == SUB_LAST) && (sub_idx_q == 4'hF) &&
                     (dig_q == DIG_LAST);
  assign boundary  = !run || frame_end;

  // Staging is always loaded; a write landing on a boundary goes straight to active.
  assign dig_stage_d = wr_dig ? wdata[NIB_W-1:0] : dig_stage_q;
  assign dp_stage_d  = wr_dp  ? wdata[NDIG-1:0]  : dp_stage_q;
  assign dig_act_d   = boundary ? dig_stage_d : dig_act_q;
  assign dp_act_d    = boundary ? dp_stage_d  : dp_act_q;
  assign pend_d      = boundary ? 1'b0 : (pend_q | wr_dig | wr_dp);
  assign frame_d     = (run && frame_end) ? frame_q + 16'd1 : frame_q;

  always_comb begin
    sub_cnt_d = sub_cnt_q + SUB_W'(1);
    sub_idx_d = sub_idx_q;
    dig_d     = dig_q;
    if (!run) begin
      sub_cnt_d = '0;
      sub_idx_d = '0;
      dig_d     = '0;
    end else if (sub_cnt_q == SUB_LAST) begin
      sub_cnt_d = '0;
      sub_idx_d = sub_idx_q + 4'd1;
      if (sub_idx_q == 4'hF) begin
        dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin : p_lz
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above  = zero_above && (dig_act_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_above && (i != 0);
    end
  end

  always_comb begin
    nib_cur   = '0;
    dp_cur    = 1'b0;
    blank_cur = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_q == DIG_W'(i)) begin
        nib_cur   = dig_act_q[4*i +: 4];
        dp_cur    = dp_act_q[i];
        blank_cur = lz_blank[i];
      end
    end
  end

  seg7_hexdec u_hexdec (
    .nib_i (nib_cur),
    .seg_o (glyph_cur)
  );

  always_comb begin
    com_d = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (run && !(ctrl_d.blank && blank_cur)) begin
      seg_d = glyph_cur;
      dp_d  = dp_cur;
      for (int i = 0; i < NDIG; i++) begin
        com_d[i] = (dig_q == DIG_W'(i)) && (sub_idx_q <= ctrl_d.bright);
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (addr)
        REG_DIGITS: rdata_d = 32'(dig_stage_q);
        REG_DP:     rdata_d = 32'(dp_stage_q);
        REG_CTRL:   rdata_d = ctrl_pack(ctrl_q);
        default: begin
          rdata_d                = '0;
          rdata_d[15:0]          = frame_q;
          rdata_d[STAT_PEND_BIT] = pend_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= CTRL_RESET;
      dig_stage_q <= '0;
      dig_act_q   <= '0;
      dp_stage_q  <= '0;
      dp_act_q    <= '0;
      pend_q      <= 1'b0;
      frame_q     <= '0;
      sub_cnt_q   <= '0;
      sub_idx_q   <= '0;
      dig_q       <= '0;
      rdata_q     <= '0;
      com_q       <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      dig_stage_q <= dig_stage_d;
      dig_act_q   <= dig_act_d;
      dp_stage_q  <= dp_stage_d;
      dp_act_q    <= dp_act_d;
      pend_q      <= pend_d;
      frame_q     <= frame_d;
      sub_cnt_q   <= sub_cnt_d;
      sub_idx_q   <= sub_idx_d;
      dig_q       <= dig_d;
      rdata_q     <= rdata_d;
      com_q       <= com_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign rdata  = rdata_q;
  assign oCOM   = com_q ^ {NDIG{COM_ACT_LOW}};
  assign oSEG   = seg_q ^ {7{SEG_ACT_LOW}};
  assign oSEGDP = dp_q ^ SEG_ACT_LOW;

endmodule
